// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding buffer so consecutive bytes go out with no idle gap.
// txd is registered: each transition writes the line level for the state being entered.
module uart_tx #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [7:0]    hold_data;
  logic          hold_full;
  logic          bit_end;
  logic          accept;
  logic          load;

  assign bit_end  = (baud_cnt == CNT_LAST);
  assign accept   = tx_valid & ~hold_full;
  // load needs full and accept needs !full, so the two never coincide
  assign load     = hold_full & ((state == S_IDLE) | ((state == S_STOP) & bit_end));
  assign tx_ready = ~hold_full;
  assign tx_busy  = (state != S_IDLE) | hold_full;

  // Data path: buffer and shifter carry no reset; hold_full alone decides whether hold_data is live
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= tx_data;
    end
    if (load) begin
      shift_reg <= hold_data;
    end else if ((state == S_DATA) && bit_end) begin
      shift_reg <= shift_reg >> 1;
    end
  end

  // Control path
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      hold_full <= 1'b0;
      txd       <= 1'b1;
    end else begin
      if (load) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (hold_full) begin
            state <= S_START;
            txd   <= 1'b0;
          end else begin
            txd <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state    <= S_DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              txd   <= 1'b1;
            end else begin
              // shift_reg[1] is the bit that lands in [0] on this same edge
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (hold_full) begin
              state <= S_START;
              txd   <= 1'b0;
            end else begin
              state <= S_IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (CLK_DIV 4, 8, 2) checked every cycle against a frame-timeline model,
// plus a table of single-byte frames and directed multi-cycle sequences.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] valid_v;
  logic [2:0] ready_v;
  logic [2:0] txd_v;
  logic [2:0] busy_v;
  logic [7:0] data_v [3];

  uart_tx #(.CLK_DIV(4)) u_div4 (.clk(clk), .reset(rst_v[0]), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
                                 .tx_ready(ready_v[0]), .txd(txd_v[0]), .tx_busy(busy_v[0]));
  uart_tx #(.CLK_DIV(8)) u_div8 (.clk(clk), .reset(rst_v[1]), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
                                 .tx_ready(ready_v[1]), .txd(txd_v[1]), .tx_busy(busy_v[1]));
  uart_tx #(.CLK_DIV(2)) u_div2 (.clk(clk), .reset(rst_v[2]), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
                                 .tx_ready(ready_v[2]), .txd(txd_v[2]), .tx_busy(busy_v[2]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: each accepted byte becomes a frame with an accept edge and a start edge on a timeline
  typedef struct {
    int         acc;
    int         s;
    logic [7:0] b;
  } frame_t;

  frame_t fq [3][$];
  int     last_end [3];

  function automatic int divk(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 8 : 2);
  endfunction

  function automatic logic exp_txd(input int k, input int t);
    for (int i = 0; i < fq[k].size(); i++) begin
      int o;
      int idx;
      logic [7:0] bb;
      o  = t - fq[k][i].s;
      bb = fq[k][i].b;
      if (o >= 0 && o < 10 * divk(k)) begin
        idx = o / divk(k);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return bb[idx-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_ready(input int k, input int t);
    for (int i = 0; i < fq[k].size(); i++) begin
      if (fq[k][i].acc <= t && t < fq[k][i].s) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int k, input int t);
    if (!exp_ready(k, t)) return 1'b1;
    for (int i = 0; i < fq[k].size(); i++) begin
      if (t >= fq[k][i].s && t < fq[k][i].s + 10 * divk(k)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_edge();
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst_v[k]) begin
        fq[k].delete();
        last_end[k] = 0;
      end else if (valid_v[k] && exp_ready(k, cyc - 1)) begin
        frame_t f;
        f.acc = cyc;
        f.s   = (cyc + 1 > last_end[k]) ? cyc + 1 : last_end[k];
        f.b   = data_v[k];
        last_end[k] = f.s + 10 * divk(k);
        fq[k].push_back(f);
      end
      while (fq[k].size() > 0 && fq[k][0].s + 10 * divk(k) < cyc) void'(fq[k].pop_front());
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("txd_%0d", k), txd_v[k], exp_txd(k, cyc));
      chk($sformatf("ready_%0d", k), ready_v[k], exp_ready(k, cyc));
      chk($sformatf("busy_%0d", k), busy_v[k], exp_busy(k, cyc));
    end
  endtask

  task automatic send(input int k, input logic [7:0] b);
    int   n;
    logic hs;
    n = 0;
    data_v[k]  = b;
    valid_v[k] = 1'b1;
    do begin
      hs = ready_v[k];
      cycle();
      n++;
    end while (!hs && n < 500);
    valid_v[k] = 1'b0;
    chk($sformatf("send_hs_%0d", k), hs, 1'b1);
  endtask

  typedef struct {
    int         k;
    logic [7:0] b;
    int         len;
    int         zeros;
  } vec_t;

  vec_t tbl [3];

  initial begin
    int         n;
    int         len;
    int         zeros;
    int         t0;
    int         idx;
    logic       hs;
    logic [2:0] hsv;
    logic [7:0] bytes [3];

    tbl[0] = '{k: 0, b: 8'h2F, len: 40, zeros: 16};
    tbl[1] = '{k: 1, b: 8'hA5, len: 80, zeros: 40};
    tbl[2] = '{k: 2, b: 8'h80, len: 20, zeros: 16};

    rst_v   = 3'b111;
    valid_v = 3'b000;
    for (int k = 0; k < 3; k++) begin
      data_v[k]   = 8'h00;
      last_end[k] = 0;
    end
    cycle();
    cycle();
    rst_v = 3'b000;
    cycle();

    // Single frames: one idle-high cycle after accept, then frame length and low-bit count
    for (int i = 0; i < 3; i++) begin
      send(tbl[i].k, tbl[i].b);
      chk("lead_high", txd_v[tbl[i].k], 1'b1);
      n = 0;
      do begin cycle(); n++; end while (txd_v[tbl[i].k] && n < 10);
      chk_int("fall_delay", n, 1);
      len = 0;
      zeros = 0;
      while (busy_v[tbl[i].k] && len < 2000) begin
        if (!txd_v[tbl[i].k]) zeros++;
        len++;
        cycle();
      end
      chk_int("frame_len", len, tbl[i].len);
      chk_int("frame_zeros", zeros, tbl[i].zeros);
      repeat (3) cycle();
    end

    // Back-to-back 0xF0 then 0xFF on CLK_DIV=4
    send(0, 8'hF0);
    t0 = cyc;
    repeat (10) cycle();
    send(0, 8'hFF);
    chk("b2b_ready_low", ready_v[0], 1'b0);
    n = 0;
    while (busy_v[0] && n < 500) begin cycle(); n++; end
    chk_int("b2b_len", cyc - (t0 + 1), 80);
    repeat (3) cycle();

    // Backpressure: valid held high across three bytes on CLK_DIV=2
    bytes[0] = 8'h01;
    bytes[1] = 8'h02;
    bytes[2] = 8'h03;
    idx = 0;
    n = 0;
    data_v[2]  = bytes[0];
    valid_v[2] = 1'b1;
    while (idx < 3 && n < 500) begin
      hs = ready_v[2];
      cycle();
      n++;
      if (hs) begin
        idx++;
        if (idx < 3) data_v[2] = bytes[idx];
      end
    end
    valid_v[2] = 1'b0;
    chk_int("bp_accepted", idx, 3);
    n = 0;
    while (busy_v[2] && n < 500) begin cycle(); n++; end

    // Reset during data bit 3 on CLK_DIV=8
    send(1, 8'hA5);
    cycle();
    repeat (34) cycle();
    rst_v[1] = 1'b1;
    cycle();
    rst_v[1] = 1'b0;
    chk("rst_txd", txd_v[1], 1'b1);
    chk("rst_ready", ready_v[1], 1'b1);
    chk("rst_busy", busy_v[1], 1'b0);
    repeat (100) cycle();

    // Reset and valid on the same edge: byte must not be taken
    rst_v[1]   = 1'b1;
    valid_v[1] = 1'b1;
    data_v[1]  = 8'h3C;
    cycle();
    rst_v[1]   = 1'b0;
    valid_v[1] = 1'b0;
    chk("rstv_busy", busy_v[1], 1'b0);
    chk("rstv_ready", ready_v[1], 1'b1);
    repeat (20) cycle();

    // Accept exactly on the edge that ends STOP: one idle-high cycle, then the new frame
    send(0, 8'h33);
    repeat (40) cycle();
    data_v[0]  = 8'h55;
    valid_v[0] = 1'b1;
    cycle();
    valid_v[0] = 1'b0;
    chk("last_idle_txd", txd_v[0], 1'b1);
    chk("last_idle_busy", busy_v[0], 1'b1);
    cycle();
    chk("last_start_txd", txd_v[0], 1'b0);
    repeat (45) cycle();

    // Random traffic with occasional resets
    repeat (3000) begin
      for (int k = 0; k < 3; k++) hsv[k] = valid_v[k] & ready_v[k];
      cycle();
      for (int k = 0; k < 3; k++) begin
        if (hsv[k]) valid_v[k] = 1'b0;
        if (!valid_v[k] && $urandom_range(0, 3) == 0) begin
          valid_v[k] = 1'b1;
          data_v[k]  = 8'($urandom);
        end
        rst_v[k] = ($urandom_range(0, 599) == 0);
      end
    end
    rst_v   = 3'b000;
    valid_v = 3'b000;
    repeat (100) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter: the transmit half of the SoC UART, the counterpart of the existing receiver. It accepts bytes from the CPU-side UART register logic over a valid/ready handshake and serializes them as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) on `txd`. A one-entry holding buffer allows back-to-back frames with no idle gap on the line.

## Interface
Parameters:
- `CLK_DIV`, default 16: `clk` cycles per bit period. Legal range 2..65535.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `tx_data`  in  8: byte to send. Sampled when `tx_valid & tx_ready`.
- `tx_valid`  in  1: producer has a byte on `tx_data`.
- `tx_ready`  out  1: holding buffer is empty and can accept a byte.
- `txd`  out  1: serial line, idle high. Registered output.
- `tx_busy`  out  1: a frame is in progress or the holding buffer is full.

## Operation
- Reset values: `txd`=1, `tx_ready`=1, `tx_busy`=0, FSM=IDLE, buffer empty, counters 0.
- Holding buffer: 8-bit data register plus a full flag.
  - `tx_ready` = !full.
  - Accept (`tx_valid & tx_ready` at an edge): write `tx_data` into the buffer and set full.
  - `tx_valid` while `tx_ready`=0 is ignored. The producer holds the byte until it is accepted, and no byte is lost.
- FSM states: IDLE, START, DATA, STOP. Shift register: 8 bits. Baud counter: 0..CLK_DIV-1. Bit index: 0..7.
  - IDLE: `txd`=1. If full: load the shift register from the buffer, clear full, go to START.
  - START: `txd`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: `txd`=shift[0] for CLK_DIV cycles per bit, then shift right. After bit index 7 completes, go to STOP.
  - STOP: `txd`=1 for CLK_DIV cycles. On the last STOP cycle:
    - if full: load from the buffer, clear full, go to START (no idle cycle);
    - else: go to IDLE.
- The baud counter resets to 0 on every state or bit transition. A bit ends when counter == CLK_DIV-1.
- The FSM only loads from the buffer, never directly from `tx_data`. A load and an accept cannot occur on the same edge, because a load requires full and an accept requires !full.
- `tx_busy` = (state != IDLE) | full.
- Counter width is $clog2(CLK_DIV). Arithmetic wraps only via the explicit compare-and-clear.

## Timing
- Accept at edge N while IDLE:
  - full at N;
  - load at N+1, and `txd` falls at N+1;
  - `tx_ready` is 0 for exactly one cycle, then 1 again from N+1.
- Frame length: exactly 10·CLK_DIV cycles from the `txd` falling edge to the end of the stop bit.
- Back-to-back frames: a byte accepted at any time before the last STOP cycle starts its start bit on the edge right after the previous stop bit ends. Line period is 10·CLK_DIV per byte.
- Accept on the edge that ends STOP, with the buffer previously empty: the FSM enters IDLE, loads on the next edge, and the line shows one idle-high cycle between frames.
- Reset asserted mid-frame: on the next edge all state returns to reset values. `txd`=1 immediately after that edge. The buffered byte and the frame in flight are discarded.
- Reset and `tx_valid` on the same edge: reset wins, and the byte is not accepted.

## Test plan
- Single byte: CLK_DIV=4, send 0x2F from idle → `txd` is high for 1 cycle after accept, then 4-cycle bits 0,1,1,1,1,0,1,0,0,1 (start, data LSB-first, stop). `tx_busy` deasserts 40 cycles after `txd` falls.
- Back-to-back: CLK_DIV=4, send 0xF0 and then 0xFF (the second accepted during the first frame) → 80 contiguous cycles with no idle cycle between frames. `tx_ready` is low from the second accept until the second frame starts.
- Backpressure: hold `tx_valid`=1 with three bytes 0x01, 0x02, 0x03 presented in turn, each changed only after a handshake → all three frames are emitted in order, and `tx_data` is never sampled while `tx_ready`=0.
- Reset mid-frame: CLK_DIV=8, send 0xA5, assert `reset` during data bit 3 → at the next edge `txd`=1, `tx_ready`=1, `tx_busy`=0, and no further line activity occurs.
- Minimum divider: CLK_DIV=2, send 0x80 → 20-cycle frame with `txd` low for 16 cycles (start + bits 0..6), then 4 cycles high.
- Last-cycle accept: CLK_DIV=4, accept 0x55 on the final STOP edge of a prior frame → exactly 1 idle-high cycle, then the 0x55 frame.
